// File: rtl/icache_nway_pkg.sv
// icache_nway_pkg: shared defaults, derived-width helpers and FSM state
// encoding for the N-way instruction cache. The optional performance
// counters are enabled with the ICACHE_PERF_CNT_EN macro in icache_nway.
package icache_nway_pkg;

  localparam int ICACHE_WAYS       = 2;
  localparam int ICACHE_SETS       = 128;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_ADDR_W     = 32;

  typedef enum logic [1:0] {
    ST_LOOKUP    = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_REFILL    = 2'd3
  } icache_state_e;

  // Byte-offset width of a line: word select plus the two byte bits.
  function automatic int icache_ofs_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int icache_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // A direct-mapped cache still needs a one-bit pointer/way field.
  function automatic int icache_ptr_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// icache_victim_sel: picks the refill victim for one set. The lowest-index
// invalid way wins; when every way is valid the round-robin pointer decides
// and o_used_ptr tells the caller to advance that pointer.
module icache_victim_sel import icache_nway_pkg::*; #(
  parameter int  WAYS  = ICACHE_WAYS,
  localparam int PTR_W = icache_ptr_w(WAYS)
) (
  input  logic [WAYS-1:0]  i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_victim,
  output logic             o_used_ptr
);

  // Descending scan so the lowest invalid way is the last one assigned
  always_comb begin
    o_victim   = i_ptr;
    o_used_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        o_victim   = PTR_W'(w);
        o_used_ptr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdp_bram.sv
// sdp_bram: simple dual-port block RAM, one write port and one registered
// read port with read enable (output holds while the enable is low).
module sdp_bram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Synchronous read port; data holds when not enabled
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache between IF and the
// memory bridge. One-cycle hit latency, blocking single-line refill with a
// return-buffer bypass. Define ICACHE_PERF_CNT_EN to add the perf_hit /
// perf_miss saturating counter ports.
module icache_nway import icache_nway_pkg::*; #(
  parameter int WAYS       = ICACHE_WAYS,
  parameter int SETS       = ICACHE_SETS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int ADDR_W     = ICACHE_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    req_ready,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_inst,
  output logic                    mem_req_valid,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_rsp_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]             perf_hit,
  output logic [31:0]             perf_miss
`endif
);

  localparam int OFS_W  = icache_ofs_w(LINE_WORDS);
  localparam int IDX_W  = icache_idx_w(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFS_W;
  localparam int WSEL_W = OFS_W - 2;
  localparam int PTR_W  = icache_ptr_w(WAYS);
  localparam int LINE_W = 32 * LINE_WORDS;

  icache_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_req_addr;
  logic               r_lookup;      // an accepted request is being looked up
  logic               r_flush_pend;  // miss was squashed; refill stays silent
  logic [LINE_W-1:0]  r_rbuf;
  logic [31:0]        r_rsp_hold;
  logic [WAYS-1:0]    r_valid [SETS];
  logic [PTR_W-1:0]   r_ptr   [SETS];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [WSEL_W-1:0]  w_wsel;
  logic [LINE_W-1:0]  w_data_rd [WAYS];
  logic [TAG_W-1:0]   w_tag_rd  [WAYS];
  logic               w_hit;
  logic [PTR_W-1:0]   w_hit_way;
  logic [LINE_W-1:0]  w_hit_line;
  logic [31:0]        w_hit_word;
  logic [31:0]        w_fill_word;
  logic [31:0]        w_rsp_word;
  logic [PTR_W-1:0]   w_victim;
  logic               w_used_ptr;
  logic               w_accept;
  logic               w_refill_done;
  logic               w_unused_addr_lsb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) >= WAYS - 1) return '0;
    return p + 1'b1;
  endfunction

  assign w_idx  = r_req_addr[OFS_W +: IDX_W];
  assign w_tag  = r_req_addr[ADDR_W-1 -: TAG_W];
  assign w_wsel = r_req_addr[2 +: WSEL_W];
  assign w_unused_addr_lsb = ^r_req_addr[1:0];

  assign w_accept      = req_valid & req_ready;
  assign w_refill_done = (r_state == ST_REFILL) & (~stall | flush);
  assign mem_req_addr  = {r_req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  // Tag compare across ways; the lowest matching way wins
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_idx][w] && (w_tag_rd[w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = PTR_W'(w);
      end
    end
  end

  assign w_hit_line  = w_data_rd[w_hit_way];
  assign w_hit_word  = w_hit_line[{w_wsel, 5'b0} +: 32];
  assign w_fill_word = r_rbuf[{w_wsel, 5'b0} +: 32];
  assign w_rsp_word  = (r_state == ST_REFILL) ? w_fill_word : w_hit_word;
  assign rsp_inst    = rsp_valid ? w_rsp_word : r_rsp_hold;

  icache_victim_sel #(.WAYS(WAYS)) u_victim (
    .i_valid    (r_valid[w_idx]),
    .i_ptr      (r_ptr[w_idx]),
    .o_victim   (w_victim),
    .o_used_ptr (w_used_ptr)
  );

  for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
    logic w_we;
    assign w_we = w_refill_done & (w_victim == PTR_W'(gw));

    sdp_bram #(.WIDTH(LINE_W), .DEPTH(SETS)) u_data (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_idx),
      .i_wdata (r_rbuf),
      .i_re    (w_accept),
      .i_raddr (req_addr[OFS_W +: IDX_W]),
      .o_rdata (w_data_rd[gw])
    );

    sdp_bram #(.WIDTH(TAG_W), .DEPTH(SETS)) u_tag (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_idx),
      .i_wdata (w_tag),
      .i_re    (w_accept),
      .i_raddr (req_addr[OFS_W +: IDX_W]),
      .o_rdata (w_tag_rd[gw])
    );
  end

  // FSM next state and handshake outputs; flush overrides stall
  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    mem_req_valid = 1'b0;
    case (r_state)
      ST_LOOKUP: begin
        req_ready = flush | (~stall & ~(r_lookup & ~w_hit));
        rsp_valid = r_lookup & w_hit & ~flush;
        if (r_lookup & ~w_hit & ~flush & ~stall) w_state_nxt = ST_MISS_REQ;
      end
      ST_MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (mem_rsp_valid) w_state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        rsp_valid = ~r_flush_pend & ~flush;
        if (w_refill_done) w_state_nxt = ST_LOOKUP;
      end
      default: w_state_nxt = ST_LOOKUP;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_LOOKUP;
    else     r_state <= w_state_nxt;
  end

  // Lookup-pending and pending-flush control flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lookup     <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      if (r_state != ST_LOOKUP)   r_lookup <= 1'b0;
      else if (w_accept)          r_lookup <= 1'b1;
      else if (~stall | flush)    r_lookup <= 1'b0;

      if (((r_state == ST_MISS_REQ) | (r_state == ST_MISS_WAIT)) & flush)
        r_flush_pend <= 1'b1;
      else if (w_refill_done)
        r_flush_pend <= 1'b0;
    end
  end

  // Request address and refill return buffer
  always_ff @(posedge clk) begin
    if (w_accept) r_req_addr <= req_addr;
    if ((r_state == ST_MISS_WAIT) & mem_rsp_valid) r_rbuf <= mem_rsp_data;
  end

  // Last delivered instruction, held while no response is presented
  always_ff @(posedge clk) begin
    if (rst)            r_rsp_hold <= '0;
    else if (rsp_valid) r_rsp_hold <= w_rsp_word;
  end

  // Valid bits and round-robin pointers, updated when a refill retires
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else if (w_refill_done) begin
      r_valid[w_idx][w_victim] <= 1'b1;
      if (w_used_ptr) r_ptr[w_idx] <= ptr_inc(r_ptr[w_idx]);
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Count each lookup once, at the cycle it resolves unflushed and unstalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if ((r_state == ST_LOOKUP) & r_lookup & ~flush & ~stall) begin
      if (w_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
      else       r_miss_cnt <= sat_inc(r_miss_cnt);
    end
  end

  assign perf_hit  = r_hit_cnt;
  assign perf_miss = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed + randomized bench for icache_nway (default
// build). A line-level reference model (resident line addresses per set,
// fill-invalid-first then round-robin) predicts hit/miss and data.
module tb_icache_nway;

  localparam int WAYS = 2;
  localparam int SETS = 128;
  localparam int LW   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [31:0]  req_addr = '0;
  logic         req_ready;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         rsp_valid;
  logic [31:0]  rsp_inst;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready = 1'b0;
  logic         mem_rsp_valid = 1'b0;
  logic [32*LW-1:0] mem_rsp_data = '0;

  int checks = 0;
  int errors = 0;

  // Reference model: which line addresses (addr[31:4]) live in each set
  bit [27:0] m_line [SETS][WAYS];
  bit        m_val  [SETS][WAYS];
  int        m_ptr  [SETS];

  icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .stall         (stall),
    .flush         (flush),
    .rsp_valid     (rsp_valid),
    .rsp_inst      (rsp_inst),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Backing memory contents: a fixed function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa == 32'h1C00_0008) return 32'hDEAD_BEEF;
    return (wa * 32'd2654435761) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [32*LW-1:0] mem_line(input logic [31:0] a);
    logic [32*LW-1:0] l;
    for (int k = 0; k < LW; k++)
      l[32*k +: 32] = mem_word({a[31:4], 4'b0} + 32'(4 * k));
    return l;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int s;
    s = int'(a[10:4]);
    for (int w = 0; w < WAYS; w++)
      if (m_val[s][w] && m_line[s][w] == a[31:4]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_fill(input logic [31:0] a);
    int s, v;
    s = int'(a[10:4]);
    v = -1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!m_val[s][w]) v = w;
    if (v < 0) begin
      v = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
    m_val[s][v]  = 1'b1;
    m_line[s][v] = a[31:4];
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
    end
  endtask

  // One complete fetch, entered and left at a falling edge
  task automatic fetch(input logic [31:0] a);
    bit          hit;
    logic [31:0] exp;
    int          n;
    hit = m_hit(a);
    exp = mem_word(a);
    req_valid = 1'b1;
    req_addr  = a;
    #1 chk1("fetch_req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    #1;
    if (hit) begin
      chk1("hit_rsp_valid", rsp_valid, 1'b1);
      chk32("hit_rsp_inst", rsp_inst, exp);
      chk1("hit_no_mem_req", mem_req_valid, 1'b0);
    end else begin
      chk1("miss_rsp_valid", rsp_valid, 1'b0);
      chk1("miss_req_ready", req_ready, 1'b0);
      @(negedge clk);
      #1 chk1("miss_mem_req_valid", mem_req_valid, 1'b1);
      chk32("miss_mem_req_addr", mem_req_addr, {a[31:4], 4'b0});
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        #1 chk1("mem_req_held", mem_req_valid, 1'b1);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      #1 chk1("mem_req_dropped", mem_req_valid, 1'b0);
      n = $urandom_range(0, 2);
      repeat (n) @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_line(a);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
      #1 chk1("refill_rsp_valid", rsp_valid, 1'b1);
      chk32("refill_rsp_inst", rsp_inst, exp);
      m_fill(a);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    m_reset();

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk32("rst_rsp_inst", rsp_inst, 32'h0);
    chk1("rst_req_ready", req_ready, 1'b1);
    @(negedge clk);

    // Cold miss, DEADBEEF from word 2, then hit on the same line
    fetch(32'h1C00_0008);
    fetch(32'h1C00_0004);

    // Streaming hits over two resident lines
    fetch(32'h1C00_0010);
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        req_valid = 1'b1;
        req_addr  = 32'h1C00_0000 + 32'(4 * i);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        chk1("stream_rsp_valid", rsp_valid, 1'b1);
        chk32("stream_rsp_inst", rsp_inst, mem_word(32'h1C00_0000 + 32'(4 * (i - 1))));
        chk1("stream_no_mem_req", mem_req_valid, 1'b0);
      end
      if (i < 8) chk1("stream_req_ready", req_ready, 1'b1);
      @(negedge clk);
    end

    // Conflict in one set: third fill evicts way0, re-fetch of first misses
    fetch(32'h2000_0040);
    fetch(32'h2000_0840);
    fetch(32'h2000_1040);
    fetch(32'h2000_0044);
    fetch(32'h2000_1048);
    fetch(32'h2000_0844);

    // Flush while waiting for the refill
    a = 32'h3000_0104;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk1("fl_miss_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    #1 chk32("fl_mem_req_addr", mem_req_addr, 32'h3000_0100);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    flush = 1'b1;
    #1 chk1("fl_wait_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    repeat (2) @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = mem_line(a);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1 chk1("fl_refill_suppressed", rsp_valid, 1'b0);
    m_fill(a);
    @(negedge clk);
    #1 chk1("fl_after_rsp_valid", rsp_valid, 1'b0);
    fetch(a);

    // Flush in LOOKUP: captured hit discarded, redirect target accepted
    req_valid = 1'b1;
    req_addr  = 32'h1C00_0010;
    @(negedge clk);
    flush    = 1'b1;
    req_addr = 32'h1C00_0018;
    #1 chk1("flush_lookup_rsp_valid", rsp_valid, 1'b0);
    chk1("flush_lookup_req_ready", req_ready, 1'b1);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1 chk1("redirect_rsp_valid", rsp_valid, 1'b1);
    chk32("redirect_rsp_inst", rsp_inst, mem_word(32'h1C00_0018));
    @(negedge clk);

    // Stall on a hit for four cycles, then the waiting request is accepted
    req_valid = 1'b1;
    req_addr  = 32'h1C00_0008;
    @(negedge clk);
    stall    = 1'b1;
    req_addr = 32'h1C00_000C;
    for (int i = 0; i < 4; i++) begin
      #1 chk1("stall_rsp_valid", rsp_valid, 1'b1);
      chk32("stall_rsp_inst", rsp_inst, 32'hDEAD_BEEF);
      chk1("stall_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1 chk1("unstall_req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk1("unstall_rsp_valid", rsp_valid, 1'b1);
    chk32("unstall_rsp_inst", rsp_inst, mem_word(32'h1C00_000C));
    @(negedge clk);

    // Reset mid MISS_REQ, then a stale refill response
    req_valid = 1'b1;
    req_addr  = 32'h5000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1 chk1("rstmiss_mem_req_valid", mem_req_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    #1 chk1("rstmiss_mem_req_drop", mem_req_valid, 1'b0);
    chk1("rstmiss_rsp_valid", rsp_valid, 1'b0);
    chk32("rstmiss_rsp_inst", rsp_inst, 32'h0);
    chk1("rstmiss_req_ready", req_ready, 1'b1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = mem_line(32'h5000_0200);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1 chk1("stale_rsp_valid", rsp_valid, 1'b0);
    chk1("stale_mem_req_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    fetch(32'h1C00_0004);
    fetch(32'h5000_0200);

    // Randomized fetches over a few contended sets
    for (int i = 0; i < 40; i++) begin
      a = 32'h4000_0000
        | (32'($urandom_range(0, 3)) << 11)
        | (($urandom_range(0, 1) != 0) ? 32'h70 : 32'h30)
        | (32'($urandom_range(0, 3)) << 2)
        | 32'($urandom_range(0, 3));
      fetch(a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised N-way set-associative instruction cache between the IF stage and the memory/AXI bridge.
- Successor to the fixed 2-way, 4-word-line instruction cache. Adds:
  - configurable ways, sets and line size;
  - per-line valid bits, cleared by reset;
  - replacement that fills invalid ways first, then uses a per-set round-robin pointer;
  - a request/response handshake on both the pipeline side and the memory side;
  - a defined flush-during-miss behaviour.

Parameters:
- WAYS, 2: associativity; power of two, 1..8.
- SETS, 128: sets per way; power of two.
- LINE_WORDS, 4: 32-bit words per line; power of two, 2..16.
- ADDR_W, 32: address width.
- Derived: OFS_W = log2(LINE_WORDS)+2, IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W-OFS_W.

Ports:
- clk  in  1  clock. One clock domain; all state updates on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- req_valid  in  1  IF presents a fetch address.
- req_addr  in  ADDR_W  fetch PC; bits [1:0] are ignored.
- req_ready  out  1  cache accepts a request this cycle.
- stall  in  1  pipeline stall: hold the response and accept nothing.
- flush  in  1  squash the in-flight request (branch redirect).
- rsp_valid  out  1  rsp_inst is valid.
- rsp_inst  out  32  fetched instruction.
- mem_req_valid  out  1  line refill request.
- mem_req_addr  out  ADDR_W  line-aligned miss address (low OFS_W bits are zero).
- mem_req_ready  in  1  memory accepts the refill request.
- mem_rsp_valid  in  1  refill line is present.
- mem_rsp_data  in  32*LINE_WORDS  refill line; word 0 is in the LSBs.

Behaviour:
- Storage per way: data RAM of SETS x (32*LINE_WORDS) and tag RAM of SETS x TAG_W, both with synchronous read. Valid bits are a SETS x WAYS flop array. The round-robin pointer is a SETS x log2(WAYS) flop array.
- Reset: state=LOOKUP, all valid bits=0, all pointers=0, rsp_valid=0, mem_req_valid=0, rsp_inst=0, req_ready=1.
- States: LOOKUP, MISS_REQ, MISS_WAIT, REFILL.
- LOOKUP:
  - A request is accepted when req_valid & req_ready. Its address is captured in the request register and the RAMs are read with the index.
  - Next cycle: hit = (valid & tag match) in any way.
  - On hit: rsp_valid=1 and rsp_inst = the word selected by addr[OFS_W-1:2]. Latency is 1 cycle. req_ready stays 1, so back-to-back hits give one instruction per cycle.
  - On miss: rsp_valid=0, req_ready=0, next state MISS_REQ.
- stall:
  - req_ready=0. The request register and the RAM read enable are frozen.
  - rsp_valid and rsp_inst hold their values. No state transition from LOOKUP.
  - Miss states continue, but the REFILL response is held until stall falls.
- MISS_REQ:
  - mem_req_valid=1 with mem_req_addr stable.
  - When mem_req_ready=1, move to MISS_WAIT.
- MISS_WAIT: wait for mem_rsp_valid=1, then move to REFILL.
- Refill capture and victim choice:
  - The line is captured into a return buffer on the mem_rsp_valid cycle.
  - Victim: the lowest-index invalid way; if all ways are valid, the way given by the set's pointer.
- REFILL (one cycle):
  - Write data and tag to the victim and set its valid bit.
  - If the pointer chose the victim, the pointer increments mod WAYS; a fill into an invalid way leaves the pointer unchanged.
  - rsp_valid=1 with rsp_inst bypassed from the return buffer.
  - Back to LOOKUP with req_ready=1.
- Hit: the pointer is unchanged (round-robin, not LRU).
- flush:
  - In LOOKUP: rsp_valid=0 for that cycle and any hit/miss of the captured request is discarded. A request presented in the same cycle as flush is accepted (it is the redirect target).
  - In MISS_REQ: the request must still complete once mem_req_ready=1.
  - In MISS_REQ or MISS_WAIT: a pending-flush flag is set. The memory transaction completes, the refill is still written, rsp_valid is suppressed in REFILL, and the flag clears.
- Simultaneous stall & flush: flush wins.
- rst mid-miss: the FSM returns to LOOKUP immediately. mem_req_valid drops. A late mem_rsp_valid arriving in LOOKUP is ignored.
- Multiple tag matches cannot occur; the lowest way wins.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Two 32-bit saturating counters, hit_cnt and miss_cnt, are exposed as output ports perf_hit and perf_miss.
  - Each counts at most once per accepted, non-flushed lookup. Both clear on rst.
- Undefined: the ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package/header: WAYS/SETS/LINE_WORDS defaults, derived OFS_W/IDX_W/TAG_W, and the FSM state encoding constants.
- Natural sub-module: icache_victim_sel. It is combinational over the valid vector and the pointer, and returns the victim way and a "used pointer" flag.
- Data and tag RAMs reuse the existing simple dual-port BRAM module.

Test Plan:
- Cold miss after reset: request 0x1C000008 → mem_req_addr=0x1C000000; return line {w3,w2,w1,0xDEADBEEF at word2}; rsp_inst=word2 in REFILL; re-request 0x1C000004 → hit, rsp_valid one cycle after acceptance.
- Streaming hits: 8 sequential PCs within two resident lines → 8 rsp_valid in 8 consecutive cycles, no mem_req_valid.
- Conflict (WAYS=2): three lines mapping to the same set → third fill evicts way0 (pointer=0), pointer becomes 1; re-fetch of the first line misses.
- Flush in MISS_WAIT: flush, then mem_rsp_valid 3 cycles later → line written, rsp_valid stays 0; a later fetch of that line hits.
- Stall on hit: stall held 4 cycles → rsp_inst and rsp_valid constant, req_ready=0; after release the next request is accepted.
- Reset mid-MISS_REQ with mem_req_ready low → mem_req_valid=0 the next cycle, all lines invalid; a stale mem_rsp_valid is ignored.
